// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder. Exposes the carry into the chunk
// MSB so the caller can derive signed overflow on the top chunk.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co    = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/serial_nbit_adder.sv
// Multi-cycle adder: processes CHUNK bits per clock, LSB chunk first.
// Optional subtract support is enabled with SERIAL_NBIT_ADDER_SUBTRACT_EN.
module serial_nbit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_NBIT_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("serial_nbit_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [KW-1:0]    r_k;
  logic             r_carry, r_cout, r_ovf;

  logic [CHUNK-1:0] w_s;
  logic             w_co, w_cmsb, w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

  assign w_last = (r_k == KW'(NCHUNK - 1));

  // Operand conditioning at capture: subtract stores ~b with a forced carry of 1.
`ifdef SERIAL_NBIT_ADDER_SUBTRACT_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : c_in;
`else
  assign w_b_in = b;
  assign w_c_in = c_in;
`endif

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (r_a[r_k*CHUNK +: CHUNK]),
    .b     (r_b[r_k*CHUNK +: CHUNK]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: start only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ADD;
      ADD:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (r_state == ADD);
    done = (r_state == DONE);
  end

  // Datapath: capture operands on accept, then one chunk per ADD cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= a;
          r_b     <= w_b_in;
          r_carry <= w_c_in;
          r_k     <= '0;
        end
        ADD: begin
          r_sum[r_k*CHUNK +: CHUNK] <= w_s;
          r_carry                   <= w_co;
          r_k                       <= r_k + 1'b1;
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_co ^ w_cmsb;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_nbit_adder.sv
// Directed bench for serial_nbit_adder (WIDTH=16, CHUNK=4) with a
// queue-based scoreboard of expected results.
module tb_serial_nbit_adder;

  localparam int W  = 16;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         n_rst, start, c_in;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, overflow;
  logic [W-1:0] sum;
`ifdef SERIAL_NBIT_ADDER_SUBTRACT_EN
  logic         sub;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  serial_nbit_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef SERIAL_NBIT_ADDER_SUBTRACT_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb_);
    exp_t         m;
    logic [W-1:0] be;
    logic         c;
    logic [W:0]   r;
    be   = sb_ ? ~y : y;
    c    = sb_ ? 1'b1 : ci;
    r    = {1'b0, x} + {1'b0, be} + (W+1)'(c);
    m.s  = r[W-1:0];
    m.co = r[W];
    m.ov = (x[W-1] == be[W-1]) && (r[W-1] != x[W-1]);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Wait for done with a cycle budget; returns cycles counted after the
  // first negedge following the accepting edge.
  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = done;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb_, input bit hold);
    int   cyc;
    bit   seen;
    exp_t e;
    @(negedge clk);
    a = x; b = y; c_in = ci; start = 1'b1;
`ifdef SERIAL_NBIT_ADDER_SUBTRACT_EN
    sub = sb_;
`endif
    sb.push_back(model(x, y, ci, sb_));
    @(negedge clk);
    if (hold) begin
      a = '1;
      b = 16'h0F0F;
      c_in = ~ci;
    end else start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc, seen);
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(NC));
    e = sb.pop_front();
    check({tag, "_sum"}, 32'(sum), 32'(e.s));
    check({tag, "_cout"}, 32'(c_out), 32'(e.co));
    check({tag, "_ovf"}, 32'(overflow), 32'(e.ov));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_no_extra_done"}, 32'(done), 32'd0);
    end
    check({tag, "_sum_held"}, 32'(sum), 32'(e.s));
  endtask

  initial begin
    int   cyc;
    bit   seen;
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef SERIAL_NBIT_ADDER_SUBTRACT_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    n_rst = 1'b1;

    run_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("neg_ovf",     16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("cin_only",    16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("cin_ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("hold_start",  16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);

    // Reset after two ADD cycles abandons the operation.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum",  32'(sum), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);

    // Reset in the DONE cycle wins over the pulse.
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, seen);
    check("donerst_seen", 32'(seen), 32'd1);
    n_rst = 1'b0;
    @(negedge clk);
    check("donerst_done", 32'(done), 32'd0);
    check("donerst_sum",  32'(sum), 32'd0);
    n_rst = 1'b1;

`ifdef SERIAL_NBIT_ADDER_SUBTRACT_EN
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
